// File: rtl/write_check_pkg.sv
// Shared types for the tagged write-beat scoreboard: slot states, error codes
// and the per-slot status record the top level arbitrates over.
package write_check_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, LAST_WAIT} slot_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DATA    = 3'd1,
    ERR_OVERRUN = 3'd2,
    ERR_TAG     = 3'd3,
    ERR_REALLOC = 3'd4
  } err_code_t;

  // Beat index field is sized for the widest supported line; the top truncates.
  localparam int BEAT_IDX_MAX_W = 8;

  typedef struct packed {
    err_code_t                 code;
    logic [BEAT_IDX_MAX_W-1:0] beat;
  } slot_status_t;

endpackage

// File: rtl/write_check_slot.sv
// One tag slot: holds the expected line and beat index, checks beats for its
// own tag and reports this cycle's error (already prioritised) and completion.
module write_check_slot
  import write_check_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int BEAT_W = 8,
  parameter int TAG_W  = 4,
  parameter int MY_TAG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_request,
  input  logic              write_request_ack,
  input  logic [TAG_W-1:0]  write_request_ack_tag,
  input  logic [LINE_W-1:0] model_data,
  input  logic              data_valid,
  input  logic [TAG_W-1:0]  data_valid_tag,
  input  logic [BEAT_W-1:0] data,
  input  logic              last_data_valid,
  input  logic              retry,
  input  logic [TAG_W-1:0]  retry_tag,
  output slot_status_t      status,
  output logic              done,
  output logic              busy
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int SEL_W = $clog2(BEATS);
  localparam int IDX_W = SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(BEATS - 1);

  slot_state_t                    state_q, state_d;
  logic [BEATS-1:0][BEAT_W-1:0]   line_q, line_d;
  logic [IDX_W-1:0]               idx_q, idx_d;

  logic open_hit, beat_hit, retry_hit, at_end;
  logic d_err, ovr_err, tag_err, re_err;
  logic [SEL_W-1:0]  sel;
  logic [BEAT_W-1:0] exp_beat;

  always_comb begin
    open_hit  = write_request && write_request_ack && (write_request_ack_tag == TAG_W'(MY_TAG));
    beat_hit  = data_valid && (data_valid_tag == TAG_W'(MY_TAG));
    retry_hit = retry && (retry_tag == TAG_W'(MY_TAG));
    at_end    = (idx_q == IDX_W'(BEATS));
    // Beat 0 sits in the most significant lane of the line.
    sel       = LAST_SEL - idx_q[SEL_W-1:0];
    exp_beat  = line_q[sel];
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    idx_d   = idx_q;
    done    = 1'b0;
    d_err   = 1'b0;
    ovr_err = 1'b0;
    tag_err = 1'b0;
    re_err  = 1'b0;
    case (state_q)
      IDLE: tag_err = beat_hit || retry_hit;
      ACTIVE: begin
        if (beat_hit) begin
          if (at_end)                 ovr_err = 1'b1;
          else if (data != exp_beat)  d_err   = 1'b1;
        end
        // Retry dominates a coincident beat, including its last flag.
        if (retry_hit)                idx_d = '0;
        else if (beat_hit) begin
          if (last_data_valid)        state_d = LAST_WAIT;
          else if (!at_end)           idx_d = idx_q + IDX_W'(1);
        end
        re_err = open_hit;
      end
      LAST_WAIT: begin
        tag_err = beat_hit;
        if (retry_hit) begin
          state_d = ACTIVE;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (open_hit) begin
      state_d = ACTIVE;
      line_d  = model_data;
      idx_d   = '0;
    end
  end

  always_comb begin
    status.beat = BEAT_IDX_MAX_W'(idx_q);
    if (d_err)        status.code = ERR_DATA;
    else if (ovr_err) status.code = ERR_OVERRUN;
    else if (tag_err) status.code = ERR_TAG;
    else if (re_err)  status.code = ERR_REALLOC;
    else              status.code = ERR_NONE;
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
    line_q <= line_d;
  end

endmodule

// File: rtl/write_beat_scoreboard.sv
// Tagged multi-beat write checker: one slot per tag, lowest-tag error select,
// registered error/done outputs and a live count of busy slots.
module write_beat_scoreboard
  import write_check_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int BEAT_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write_request,
  input  logic                                write_request_ack,
  input  logic [TAG_W-1:0]                    write_request_ack_tag,
  input  logic [LINE_W-1:0]                   model_data,
  input  logic                                data_valid,
  input  logic [TAG_W-1:0]                    data_valid_tag,
  input  logic [BEAT_W-1:0]                   data,
  input  logic                                last_data_valid,
  input  logic                                retry,
  input  logic [TAG_W-1:0]                    retry_tag,
  output logic                                err_valid,
  output logic [2:0]                          err_code,
  output logic [TAG_W-1:0]                    err_tag,
  output logic [$clog2(LINE_W/BEAT_W):0]      err_beat,
  output logic                                err_sticky,
  output logic                                done,
  output logic [TAG_W-1:0]                    done_tag,
  output logic [TAG_W:0]                      outstanding
);

  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam int IDX_W    = $clog2(LINE_W / BEAT_W) + 1;

  slot_status_t [NUM_TAGS-1:0] status;
  logic [NUM_TAGS-1:0]         done_v, busy_v;

  for (genvar t = 0; t < NUM_TAGS; t++) begin : g_slot
    write_check_slot #(
      .LINE_W(LINE_W), .BEAT_W(BEAT_W), .TAG_W(TAG_W), .MY_TAG(t)
    ) u_slot (
      .clk                   (clk),
      .reset                 (reset),
      .write_request         (write_request),
      .write_request_ack     (write_request_ack),
      .write_request_ack_tag (write_request_ack_tag),
      .model_data            (model_data),
      .data_valid            (data_valid),
      .data_valid_tag        (data_valid_tag),
      .data                  (data),
      .last_data_valid       (last_data_valid),
      .retry                 (retry),
      .retry_tag             (retry_tag),
      .status                (status[t]),
      .done                  (done_v[t]),
      .busy                  (busy_v[t])
    );
  end

  err_code_t        sel_code;
  logic [TAG_W-1:0] sel_tag, sel_done_tag;
  logic [IDX_W-1:0] sel_beat;
  logic             sel_done;
  logic [TAG_W:0]   busy_cnt;

  // Walk high to low so the lowest flagged tag is the one left standing.
  always_comb begin
    sel_code     = ERR_NONE;
    sel_tag      = '0;
    sel_beat     = '0;
    sel_done     = 1'b0;
    sel_done_tag = '0;
    busy_cnt     = '0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (status[t].code != ERR_NONE) begin
        sel_code = status[t].code;
        sel_tag  = TAG_W'(t);
        sel_beat = status[t].beat[IDX_W-1:0];
      end
      if (done_v[t]) begin
        sel_done     = 1'b1;
        sel_done_tag = TAG_W'(t);
      end
      busy_cnt = busy_cnt + (TAG_W+1)'(busy_v[t]);
    end
  end

  assign outstanding = busy_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_tag    <= '0;
      err_beat   <= '0;
      err_sticky <= 1'b0;
      done       <= 1'b0;
      done_tag   <= '0;
    end else begin
      err_valid  <= (sel_code != ERR_NONE);
      err_code   <= sel_code;
      err_tag    <= sel_tag;
      err_beat   <= sel_beat;
      err_sticky <= err_sticky | (sel_code != ERR_NONE);
      done       <= sel_done;
      done_tag   <= sel_done_tag;
    end
  end

endmodule

// File: tb/tb_write_beat_scoreboard.sv
// Directed bench for write_beat_scoreboard: one task per scenario, each with
// hand-computed expectations on the registered error/done outputs.
module tb_write_beat_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic         write_request, write_request_ack;
  logic [3:0]   write_request_ack_tag;
  logic [127:0] model_data;
  logic         data_valid;
  logic [3:0]   data_valid_tag;
  logic [7:0]   data;
  logic         last_data_valid;
  logic         retry;
  logic [3:0]   retry_tag;
  logic         err_valid;
  logic [2:0]   err_code;
  logic [3:0]   err_tag;
  logic [4:0]   err_beat;
  logic         err_sticky;
  logic         done;
  logic [3:0]   done_tag;
  logic [4:0]   outstanding;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  logic [3:0] last_done_tag = '0;
  logic [127:0] line = 128'h00112233445566778899AABBCCDDEEFF;

  write_beat_scoreboard dut (
    .clk(clk), .reset(reset),
    .write_request(write_request), .write_request_ack(write_request_ack),
    .write_request_ack_tag(write_request_ack_tag), .model_data(model_data),
    .data_valid(data_valid), .data_valid_tag(data_valid_tag), .data(data),
    .last_data_valid(last_data_valid), .retry(retry), .retry_tag(retry_tag),
    .err_valid(err_valid), .err_code(err_code), .err_tag(err_tag),
    .err_beat(err_beat), .err_sticky(err_sticky), .done(done),
    .done_tag(done_tag), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_valid) err_cnt <= err_cnt + 1;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_tag <= done_tag;
    end
  end

  function automatic logic [7:0] beat_of(input int i);
    return line[127 - 8*i -: 8];
  endfunction

  task automatic clear_inputs();
    write_request = 0; write_request_ack = 0; write_request_ack_tag = '0;
    model_data = '0; data_valid = 0; data_valid_tag = '0; data = '0;
    last_data_valid = 0; retry = 0; retry_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic open_tag(input logic [3:0] t);
    write_request = 1; write_request_ack = 1; write_request_ack_tag = t; model_data = line;
    tick(); clear_inputs();
  endtask

  task automatic send_beat(input logic [3:0] t, input logic [7:0] d, input logic lst);
    data_valid = 1; data_valid_tag = t; data = d; last_data_valid = lst;
    tick(); clear_inputs();
  endtask

  task automatic send_retry(input logic [3:0] t);
    retry = 1; retry_tag = t;
    tick(); clear_inputs();
  endtask

  task automatic send_beats(input logic [3:0] t, input int from, input int to, input logic last_at_to);
    for (int i = from; i <= to; i++) send_beat(t, beat_of(i), last_at_to && (i == to));
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs(); tick(); tick(); reset = 0;
    tests++; if (err_valid !== 1'b0) begin fails++; $display("FAIL reset err_valid: got %b want 0", err_valid); end
    tests++; if (err_code !== 3'd0) begin fails++; $display("FAIL reset err_code: got %0d want 0", err_code); end
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset err_sticky: got %b want 0", err_sticky); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", done); end
    tests++; if (outstanding !== 5'd0) begin fails++; $display("FAIL reset outstanding: got %0d want 0", outstanding); end
  endtask

  task automatic test_clean();
    int e0 = err_cnt;
    open_tag(4'd3);
    tests++; if (outstanding !== 5'd1) begin fails++; $display("FAIL clean outstanding: got %0d want 1", outstanding); end
    send_beats(4'd3, 0, 15, 1'b1);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL clean early done: got %b want 0", done); end
    tick();
    tests++; if (done !== 1'b1 || done_tag !== 4'd3) begin fails++; $display("FAIL clean done: got %b tag %0d want 1 tag 3", done, done_tag); end
    tick();
    tests++; if (done !== 1'b0 || outstanding !== 5'd0) begin fails++; $display("FAIL clean after: done %b outstanding %0d want 0 0", done, outstanding); end
    tests++; if (err_cnt != e0) begin fails++; $display("FAIL clean errors: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_mid_retry();
    int e0 = err_cnt; int d0 = done_cnt;
    open_tag(4'd5);
    send_beats(4'd5, 0, 3, 1'b0);
    send_retry(4'd5);
    send_beats(4'd5, 0, 15, 1'b1);
    tick(); tick();
    tests++; if (err_cnt != e0) begin fails++; $display("FAIL mid_retry errors: got %0d want 0", err_cnt - e0); end
    tests++; if (done_cnt != d0 + 1 || last_done_tag !== 4'd5) begin fails++; $display("FAIL mid_retry done: got %0d tag %0d want 1 tag 5", done_cnt - d0, last_done_tag); end
  endtask

  task automatic test_late_retry();
    int e0 = err_cnt; int d0 = done_cnt;
    open_tag(4'd2);
    send_beats(4'd2, 0, 15, 1'b1);
    send_retry(4'd2);
    tick(); tick();
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL late_retry done: got %0d want 0", done_cnt - d0); end
    tests++; if (outstanding !== 5'd1) begin fails++; $display("FAIL late_retry outstanding: got %0d want 1", outstanding); end
    send_beats(4'd2, 0, 15, 1'b1);
    tick(); tick();
    tests++; if (done_cnt != d0 + 1 || last_done_tag !== 4'd2) begin fails++; $display("FAIL late_retry resend done: got %0d tag %0d want 1 tag 2", done_cnt - d0, last_done_tag); end
    tests++; if (err_cnt != e0) begin fails++; $display("FAIL late_retry errors: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_data_mismatch();
    int e0 = err_cnt;
    open_tag(4'd7);
    send_beats(4'd7, 0, 3, 1'b0);
    send_beat(4'd7, 8'hAA, 1'b0);
    tests++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin fails++; $display("FAIL mismatch code: got v%b c%0d want v1 c1", err_valid, err_code); end
    tests++; if (err_tag !== 4'd7 || err_beat !== 5'd4) begin fails++; $display("FAIL mismatch where: got tag %0d beat %0d want 7 4", err_tag, err_beat); end
    tick();
    tests++; if (err_valid !== 1'b0 || err_sticky !== 1'b1) begin fails++; $display("FAIL mismatch pulse/sticky: got v%b s%b want v0 s1", err_valid, err_sticky); end
    send_beats(4'd7, 5, 15, 1'b1);
    tick(); tick();
    tests++; if (err_cnt != e0 + 1 || outstanding !== 5'd0) begin fails++; $display("FAIL mismatch tail: errors %0d outstanding %0d want 1 0", err_cnt - e0, outstanding); end
  endtask

  task automatic test_beat_retry_same();
    int d0;
    open_tag(4'd6);
    send_beats(4'd6, 0, 2, 1'b0);
    data_valid = 1; data_valid_tag = 4'd6; data = 8'h00; last_data_valid = 1;
    retry = 1; retry_tag = 4'd6;
    tick(); clear_inputs();
    tests++; if (err_code !== 3'd1 || err_tag !== 4'd6 || err_beat !== 5'd3) begin fails++; $display("FAIL beat_retry err: got c%0d t%0d b%0d want 1 6 3", err_code, err_tag, err_beat); end
    tick();
    d0 = done_cnt;
    send_beats(4'd6, 0, 15, 1'b1);
    tick(); tick();
    tests++; if (done_cnt != d0 + 1 || last_done_tag !== 4'd6) begin fails++; $display("FAIL beat_retry done: got %0d tag %0d want 1 tag 6", done_cnt - d0, last_done_tag); end
  endtask

  task automatic test_protocol();
    int e0;
    send_beat(4'd9, 8'h00, 1'b0);
    tests++; if (err_code !== 3'd3 || err_tag !== 4'd9 || err_beat !== 5'd0) begin fails++; $display("FAIL idle_beat: got c%0d t%0d b%0d want 3 9 0", err_code, err_tag, err_beat); end
    data_valid = 1; data_valid_tag = 4'd12; retry = 1; retry_tag = 4'd10;
    tick(); clear_inputs();
    tests++; if (err_code !== 3'd3 || err_tag !== 4'd10) begin fails++; $display("FAIL lowest_tag: got c%0d t%0d want 3 10", err_code, err_tag); end
    open_tag(4'd1);
    open_tag(4'd1);
    tests++; if (err_valid !== 1'b1 || err_code !== 3'd4 || err_tag !== 4'd1) begin fails++; $display("FAIL realloc: got v%b c%0d t%0d want 1 4 1", err_valid, err_code, err_tag); end
    tick();
    e0 = err_cnt;
    send_beats(4'd1, 0, 15, 1'b0);
    tests++; if (err_valid !== 1'b0) begin fails++; $display("FAIL overrun early: got v%b c%0d want v0", err_valid, err_code); end
    send_beat(4'd1, 8'h00, 1'b0);
    tests++; if (err_code !== 3'd2 || err_tag !== 4'd1 || err_beat !== 5'd16) begin fails++; $display("FAIL overrun: got c%0d t%0d b%0d want 2 1 16", err_code, err_tag, err_beat); end
    send_beat(4'd1, 8'h00, 1'b1);
    tick(); tick();
    tests++; if (err_cnt != e0 + 2 || outstanding !== 5'd0) begin fails++; $display("FAIL overrun tail: errors %0d outstanding %0d want 2 0", err_cnt - e0, outstanding); end
  endtask

  task automatic test_concurrency_reset();
    int e0;
    open_tag(4'd0);
    open_tag(4'd15);
    e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      send_beat(4'd0, beat_of(i), 1'b0);
      send_beat(4'd15, beat_of(i), 1'b0);
    end
    tests++; if (outstanding !== 5'd2) begin fails++; $display("FAIL interleave outstanding: got %0d want 2", outstanding); end
    tick();
    tests++; if (err_cnt != e0) begin fails++; $display("FAIL interleave errors: got %0d want 0", err_cnt - e0); end
    reset = 1; tick(); reset = 0;
    tests++; if (outstanding !== 5'd0) begin fails++; $display("FAIL post_reset outstanding: got %0d want 0", outstanding); end
    tests++; if (err_valid !== 1'b0 || err_sticky !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL post_reset outputs: v%b s%b d%b want 0 0 0", err_valid, err_sticky, done); end
    e0 = err_cnt;
    tick(); tick();
    tests++; if (err_cnt != e0) begin fails++; $display("FAIL post_reset quiet: got %0d errors want 0", err_cnt - e0); end
    send_beat(4'd0, beat_of(6), 1'b0);
    tests++; if (err_code !== 3'd3 || err_tag !== 4'd0) begin fails++; $display("FAIL post_reset beat: got c%0d t%0d want 3 0", err_code, err_tag); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_mid_retry();
    test_late_retry();
    test_data_mismatch();
    test_beat_retry_same();
    test_protocol();
    test_concurrency_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
